// File: rtl/uart_rx_buffer.sv
// 8N1 UART receiver with a small power-of-two FIFO on the output side.
// Byte lands in the FIFO on the stop-bit sample; overflow is sticky, framing_error pulses.
module uart_rx_buffer #(
  parameter int CPU_CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE      = 115_200,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       overflow,
  output logic       framing_error
);

  localparam int DATA_W         = 8;
  localparam int CLOCKS_PER_BIT = CPU_CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME    = CLOCKS_PER_BIT / 2;
  localparam int CNT_W          = $clog2(CLOCKS_PER_BIT);
  localparam int AW             = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SAMPLE_TIME - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_buffer: FIFO_DEPTH must be a power of two >= 2");
  end
  if (CLOCKS_PER_BIT < 2) begin : g_bad_rate
    $error("uart_rx_buffer: CPU_CLOCK_FREQ/BAUD_RATE must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  logic              sync1_q;
  logic              sync2_q;
  state_t            state_q,  state_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [2:0]        bit_q,    bit_d;
  logic [DATA_W-1:0] shift_q,  shift_d;
  logic              fe_q,     fe_d;
  logic              push;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              ovf_q,    ovf_d;
  logic [DATA_W-1:0] hold_q,   hold_d;
  logic              empty;
  logic              full;
  logic              pop;
  logic              wr_en;
  logic              rx;

  assign rx = sync2_q;

  // Receive FSM: every decision is taken on the synchronized line.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    fe_d    = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx) begin
          state_d = START;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[DATA_W-1:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        // A held-low line (break) must not look like a new start bit.
        if (rx) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      fe_q    <= 1'b0;
    end else begin
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      fe_q    <= fe_d;
    end
  end

  // FIFO: extra pointer MSB distinguishes full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop   = !empty && data_out_ready;
  assign wr_en = push && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    hold_d   = hold_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      hold_d   = mem_q[rd_ptr_q[AW-1:0]];
    end
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (push && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      hold_q   <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end
  end

  // An empty FIFO keeps showing the most recently consumed byte.
  assign data_out       = empty ? hold_q : mem_q[rd_ptr_q[AW-1:0]];
  assign data_out_valid = !empty;
  assign overflow       = ovf_q;
  assign framing_error  = fe_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Bench for uart_rx_buffer: frame-level reference model (queue of bytes) checked every cycle.
module tb_uart_rx_buffer;

  localparam int CPU_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DEPTH  = 4;
  localparam int CPB    = CPU_HZ / BAUD;
  localparam int LAT    = 2 + CPB / 2 + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       serial_in = 1'b1;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       ready = 1'b0;
  logic       overflow;
  logic       framing_error;

  uart_rx_buffer #(
    .CPU_CLOCK_FREQ(CPU_HZ),
    .BAUD_RATE     (BAUD),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(ready),
    .overflow      (overflow),
    .framing_error (framing_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    bit         good;
  } ev_t;

  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_start = 0;
  int         rise_cyc = 0;
  int         fe_count = 0;
  bit         prev_v = 1'b0;
  int         ready_mode = 0;
  ev_t        pend[$];
  logic [7:0] mq[$];
  logic [7:0] m_last = 8'h00;
  bit         m_ovf = 1'b0;
  bit         m_fe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: received bytes appear LAT cycles after the start edge.
  always @(posedge clk or negedge rst) begin : model
    ev_t ev;
    bit  pop;
    if (!rst) begin
      mq.delete();
      pend.delete();
      m_last = 8'h00;
      m_ovf  = 1'b0;
      m_fe   = 1'b0;
    end else begin
      cyc++;
      m_fe = 1'b0;
      pop = (mq.size() != 0) && ready;
      if (pop) m_last = mq.pop_front();
      if (pend.size() != 0 && pend[0].cyc == cyc) begin
        ev = pend.pop_front();
        if (!ev.good) m_fe = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(ev.data);
        else m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : compare
    check("valid", data_out_valid, mq.size() != 0);
    check("data_out", data_out, (mq.size() != 0) ? mq[0] : m_last);
    check("overflow", overflow, m_ovf);
    check("framing_error", framing_error, m_fe);
    if (data_out_valid === 1'b1 && !prev_v) rise_cyc = cyc;
    prev_v = (data_out_valid === 1'b1);
    if (framing_error === 1'b1) fe_count++;
  end

  always @(negedge clk) begin : ready_drv
    if (ready_mode == 2) ready = 1'($urandom_range(0, 1));
    else ready = (ready_mode == 1);
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    ev_t ev;
    @(negedge clk);
    last_start = cyc;
    ev.cyc  = cyc + LAT;
    ev.data = b;
    ev.good = stop_ok;
    pend.push_back(ev);
    serial_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    serial_in = stop_ok;
    repeat (CPB) @(negedge clk);
    serial_in = 1'b1;
  endtask

  task automatic pulse_ready();
    @(posedge clk); #1 ready_mode = 1;
    @(posedge clk); #1 ready_mode = 0;
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    @(negedge clk);
    check(name, data_out, exp);
    pulse_ready();
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin : stim
    int guard;
    int gap;
    bit ok;
    logic [7:0] b;
    repeat (3) @(negedge clk);
    check("reset_valid", data_out_valid, 1'b0);
    check("reset_data", data_out, 8'h00);
    check("reset_ovf", overflow, 1'b0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte, latency pinned to the start edge.
    send_frame(8'hA5, 1'b1);
    repeat (5) @(negedge clk);
    check("a5_data", data_out, 8'hA5);
    check("a5_valid", data_out_valid, 1'b1);
    check("a5_ovf", overflow, 1'b0);
    check("a5_latency", rise_cyc - last_start, 98);
    pulse_ready();
    @(negedge clk);
    check("a5_popped", data_out_valid, 1'b0);
    check("a5_hold", data_out, 8'hA5);

    // Five bytes into a four-entry FIFO.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    repeat (3) @(negedge clk);
    check("ovf_set", overflow, 1'b1);
    for (int i = 1; i <= 4; i++) pop_expect("ovf_pop", 8'(i));
    @(negedge clk);
    check("ovf_empty", data_out_valid, 1'b0);

    // Full FIFO with a pop on the same edge as the push.
    do_reset();
    repeat (5) @(negedge clk);
    check("rst_ovf_clear", overflow, 1'b0);
    send_frame(8'h10, 1'b1);
    send_frame(8'h20, 1'b1);
    send_frame(8'h30, 1'b1);
    send_frame(8'h40, 1'b1);
    fork
      send_frame(8'h50, 1'b1);
      begin
        repeat (3) @(negedge clk);
        guard = 0;
        while (cyc != last_start + LAT - 1 && guard < 300) begin
          @(posedge clk); #1;
          guard++;
        end
        ready_mode = 1;
        @(posedge clk); #1 ready_mode = 0;
      end
    join
    check("full_pop_sync", guard < 300, 1'b1);
    repeat (3) @(negedge clk);
    check("full_pop_ovf", overflow, 1'b0);
    pop_expect("full_pop_seq", 8'h20);
    pop_expect("full_pop_seq", 8'h30);
    pop_expect("full_pop_seq", 8'h40);
    pop_expect("full_pop_seq", 8'h50);

    // Glitch, then a bad stop bit, then a good byte.
    @(negedge clk);
    serial_in = 1'b0;
    repeat (3) @(negedge clk);
    serial_in = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_fe", fe_count, 0);
    check("glitch_valid", data_out_valid, 1'b0);
    send_frame(8'h77, 1'b0);
    repeat (20) @(negedge clk);
    check("fe_once", fe_count, 1);
    check("fe_nopush", data_out_valid, 1'b0);
    send_frame(8'h3C, 1'b1);
    repeat (3) @(negedge clk);
    check("after_fe_data", data_out, 8'h3C);
    pulse_ready();

    // Reset in the middle of the 4th data bit of 0xFF.
    @(negedge clk);
    serial_in = 1'b0;
    repeat (CPB) @(negedge clk);
    serial_in = 1'b1;
    repeat (3 * CPB + CPB / 2) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (150) @(negedge clk);
    check("rst_mid_nobyte", data_out_valid, 1'b0);
    send_frame(8'h5A, 1'b1);
    repeat (3) @(negedge clk);
    check("rst_mid_data", data_out, 8'h5A);
    check("rst_mid_ovf", overflow, 1'b0);
    pulse_ready();

    // Randomized traffic with random consumer back-pressure.
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1 ready_mode = ($urandom_range(0, 3) == 0) ? 0 : 2;
      b   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 9) != 0);
      gap = $urandom_range(0, 12);
      send_frame(b, ok);
      if (!ok) gap += 15;
      repeat (gap) @(negedge clk);
    end
    @(posedge clk); #1 ready_mode = 1;
    repeat (20) @(negedge clk);
    check("drain_empty", data_out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
